// File: rtl/dma_csr_multi.sv
// Multi-channel DMA CSR file: NUM_CH channel banks (CTRL/STATUS/DESC_PTR) plus a
// global bank (IRQ_PEND/ID), zero-wait writes and fixed-latency reads.
module dma_csr_multi #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RD_LAT   = 2,
    parameter logic [31:0] ID_VALUE = 32'h444D_0002
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     csr_wr_i,
    input  logic                     csr_rd_i,
    input  logic [ADDR_W-1:0]        csr_addr_i,
    input  logic [31:0]              csr_wr_data_i,
    input  logic [3:0]               csr_be_i,
    output logic                     csr_wait_rq_o,
    output logic [31:0]              csr_rd_data_o,
    output logic [NUM_CH-1:0]        ch_go_o,
    output logic [NUM_CH-1:0]        ch_abort_o,
    input  logic [NUM_CH-1:0]        ch_busy_i,
    input  logic [NUM_CH-1:0]        ch_done_i,
    input  logic [NUM_CH-1:0]        ch_err_i,
    output logic [NUM_CH*32-1:0]     ch_ctrl_o,
    output logic [NUM_CH*32-1:0]     ch_desc_ptr_o,
    output logic                     irq_o
);
    localparam int unsigned BW = ADDR_W - 4;

    typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_RD_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_cnt;
    logic [ADDR_W-3:0]   r_raddr;
    logic [31:0]         r_rd_data;
    logic [15:0]         r_user [NUM_CH];
    logic [29:0]         r_desc [NUM_CH];
    logic [NUM_CH-1:0]   r_irq_en;
    logic [NUM_CH-1:0]   r_done;
    logic [NUM_CH-1:0]   r_err;
    logic [NUM_CH-1:0]   r_go;
    logic [NUM_CH-1:0]   r_abort;
    logic                r_irq;

    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_load;
    logic [ADDR_W-3:0]   w_raddr;
    logic [31:0]         w_rd_mux;
    logic [NUM_CH-1:0]   w_pend;
    logic [NUM_CH-1:0]   w_ctrl_wr;
    logic [NUM_CH-1:0]   w_stat_wr;
    logic [NUM_CH-1:0]   w_desc_wr;
    logic [NUM_CH-1:0]   w_go_busy;
    logic                w_unused_addr;

    assign w_unused_addr = ^csr_addr_i[1:0];

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (csr_rd_i && !csr_wr_i)
                           w_next = (RD_LAT == 1) ? S_RD_DONE : S_RD_WAIT;
            S_RD_WAIT: if (r_cnt == 2'd1) w_next = S_RD_DONE;
            S_RD_DONE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_wr_acc      = (r_state == S_IDLE) && csr_wr_i;
        w_rd_acc      = (r_state == S_IDLE) && csr_rd_i && !csr_wr_i;
        w_load        = (w_next == S_RD_DONE) && (r_state != S_RD_DONE);
        csr_wait_rq_o = !reset_n || w_rd_acc || (r_state == S_RD_WAIT);
    end

    // RD_LAT=1 loads on the accept edge, before the latched address exists
    assign w_raddr = (r_state == S_IDLE) ? csr_addr_i[ADDR_W-1:2] : r_raddr;
    assign w_pend  = r_irq_en & (r_done | r_err);

    always_comb begin
        w_ctrl_wr = '0;
        w_stat_wr = '0;
        w_desc_wr = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (w_wr_acc && (csr_addr_i[ADDR_W-1:4] == BW'(n))) begin
                case (csr_addr_i[3:2])
                    2'd0:    w_ctrl_wr[n] = 1'b1;
                    2'd1:    w_stat_wr[n] = 1'b1;
                    2'd2:    w_desc_wr[n] = 1'b1;
                    default: ;
                endcase
            end
        end
        w_go_busy = w_ctrl_wr & ch_busy_i & {NUM_CH{csr_be_i[0] & csr_wr_data_i[0]}};
    end

    always_comb begin
        w_rd_mux = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (w_raddr[ADDR_W-3:2] == BW'(n)) begin
                case (w_raddr[1:0])
                    2'd0:    w_rd_mux = {r_user[n], 13'b0, 1'b0, r_irq_en[n], 1'b0};
                    2'd1:    w_rd_mux = {29'b0, r_err[n], r_done[n], ch_busy_i[n]};
                    2'd2:    w_rd_mux = {r_desc[n], 2'b00};
                    default: w_rd_mux = '0;
                endcase
            end
        end
        if (w_raddr[ADDR_W-3:2] == BW'(NUM_CH)) begin
            case (w_raddr[1:0])
                2'd0:    w_rd_mux = {{(32-NUM_CH){1'b0}}, w_pend};
                2'd1:    w_rd_mux = ID_VALUE;
                default: w_rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_raddr   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_rd_acc) begin
                r_cnt   <= 2'(RD_LAT - 1);
                r_raddr <= csr_addr_i[ADDR_W-1:2];
            end else if (r_state == S_RD_WAIT) begin
                r_cnt <= r_cnt - 2'd1;
            end
            if (w_load) r_rd_data <= w_rd_mux;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_irq_en <= '0;
            r_done   <= '0;
            r_err    <= '0;
            r_go     <= '0;
            r_abort  <= '0;
            r_irq    <= 1'b0;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                r_user[n] <= '0;
                r_desc[n] <= '0;
            end
        end else begin
            r_irq <= |w_pend;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                r_go[n]    <= w_ctrl_wr[n] & csr_be_i[0] & csr_wr_data_i[0] & ~ch_busy_i[n];
                r_abort[n] <= w_ctrl_wr[n] & csr_be_i[0] & csr_wr_data_i[2];
                if (w_ctrl_wr[n] && csr_be_i[0]) r_irq_en[n]      <= csr_wr_data_i[1];
                if (w_ctrl_wr[n] && csr_be_i[2]) r_user[n][7:0]   <= csr_wr_data_i[23:16];
                if (w_ctrl_wr[n] && csr_be_i[3]) r_user[n][15:8]  <= csr_wr_data_i[31:24];
                // hardware set dominates a same-cycle write-1-to-clear
                r_done[n] <= ch_done_i[n] |
                             (r_done[n] & ~(w_stat_wr[n] & csr_be_i[0] & csr_wr_data_i[1]));
                r_err[n]  <= ch_err_i[n] | w_go_busy[n] |
                             (r_err[n] & ~(w_stat_wr[n] & csr_be_i[0] & csr_wr_data_i[2]));
                if (w_desc_wr[n] && csr_be_i[0]) r_desc[n][5:0]   <= csr_wr_data_i[7:2];
                if (w_desc_wr[n] && csr_be_i[1]) r_desc[n][13:6]  <= csr_wr_data_i[15:8];
                if (w_desc_wr[n] && csr_be_i[2]) r_desc[n][21:14] <= csr_wr_data_i[23:16];
                if (w_desc_wr[n] && csr_be_i[3]) r_desc[n][29:22] <= csr_wr_data_i[31:24];
            end
        end
    end

    always_comb begin
        ch_ctrl_o     = '0;
        ch_desc_ptr_o = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            ch_ctrl_o[32*n +: 32]     = {r_user[n], 13'b0, 1'b0, r_irq_en[n], 1'b0};
            ch_desc_ptr_o[32*n +: 32] = {r_desc[n], 2'b00};
        end
    end

    assign csr_rd_data_o = r_rd_data;
    assign ch_go_o       = r_go;
    assign ch_abort_o    = r_abort;
    assign irq_o         = r_irq;

endmodule

// File: tb/tb_dma_csr_multi.sv
// Bench for dma_csr_multi: directed literal checks, then random traffic compared
// every cycle against a register-level behavioural model.
module tb_dma_csr_multi;
    localparam int          NUM_CH   = 4;
    localparam int          ADDR_W   = 8;
    localparam int          RD_LAT   = 2;
    localparam logic [31:0] ID_VALUE = 32'h444D_0002;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   csr_wr_i = 1'b0;
    logic                   csr_rd_i = 1'b0;
    logic [ADDR_W-1:0]      csr_addr_i = '0;
    logic [31:0]            csr_wr_data_i = '0;
    logic [3:0]             csr_be_i = '0;
    logic                   csr_wait_rq_o;
    logic [31:0]            csr_rd_data_o;
    logic [NUM_CH-1:0]      ch_go_o;
    logic [NUM_CH-1:0]      ch_abort_o;
    logic [NUM_CH-1:0]      ch_busy_i = '0;
    logic [NUM_CH-1:0]      ch_done_i = '0;
    logic [NUM_CH-1:0]      ch_err_i = '0;
    logic [NUM_CH*32-1:0]   ch_ctrl_o;
    logic [NUM_CH*32-1:0]   ch_desc_ptr_o;
    logic                   irq_o;

    always #5 clk = ~clk;

    dma_csr_multi #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .ID_VALUE(ID_VALUE)
    ) u_dut (
        .clk(clk), .reset_n(reset_n),
        .csr_wr_i(csr_wr_i), .csr_rd_i(csr_rd_i), .csr_addr_i(csr_addr_i),
        .csr_wr_data_i(csr_wr_data_i), .csr_be_i(csr_be_i),
        .csr_wait_rq_o(csr_wait_rq_o), .csr_rd_data_o(csr_rd_data_o),
        .ch_go_o(ch_go_o), .ch_abort_o(ch_abort_o),
        .ch_busy_i(ch_busy_i), .ch_done_i(ch_done_i), .ch_err_i(ch_err_i),
        .ch_ctrl_o(ch_ctrl_o), .ch_desc_ptr_o(ch_desc_ptr_o), .irq_o(irq_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register contents per channel plus read progress.
    logic [15:0]       m_user [NUM_CH];
    logic [31:0]       m_desc [NUM_CH];
    bit                m_en   [NUM_CH];
    bit                m_done [NUM_CH];
    bit                m_err  [NUM_CH];
    logic [NUM_CH-1:0] m_go, m_abort;
    logic              m_irq;
    logic [31:0]       m_rd;
    int                m_phase;   // 0 idle, k = k-th cycle since accept, RD_LAT = completing
    logic [ADDR_W-1:0] m_raddr;
    logic              last_wait;
    logic [31:0]       last_rd;

    task automatic m_clear();
        for (int n = 0; n < NUM_CH; n++) begin
            m_user[n] = '0; m_desc[n] = '0; m_en[n] = 0; m_done[n] = 0; m_err[n] = 0;
        end
        m_go = '0; m_abort = '0; m_irq = 1'b0; m_rd = '0; m_phase = 0; m_raddr = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [ADDR_W-1:0] a);
        int ch;
        int off;
        logic [31:0] pend;
        ch = int'(a) / 16;
        off = (int'(a) % 16) / 4;
        pend = '0;
        if (ch < NUM_CH) begin
            if (off == 0) return {m_user[ch], 14'b0, m_en[ch], 1'b0};
            if (off == 1) return {29'b0, m_err[ch], m_done[ch], ch_busy_i[ch]};
            if (off == 2) return m_desc[ch];
            return '0;
        end
        if (ch == NUM_CH) begin
            for (int n = 0; n < NUM_CH; n++) pend[n] = m_en[n] & (m_done[n] | m_err[n]);
            if (off == 0) return pend;
            if (off == 1) return ID_VALUE;
        end
        return '0;
    endfunction

    // Advance the model across one clock edge using the inputs held at that edge.
    task automatic m_step();
        logic irq_n;
        logic [NUM_CH-1:0] go_n, ab_n;
        bit wr_ok;
        int prev, wch, woff;
        logic [31:0] d;
        logic [3:0] be;
        if (!reset_n) begin
            m_clear();
            return;
        end
        irq_n = 1'b0;
        for (int n = 0; n < NUM_CH; n++) irq_n |= m_en[n] & (m_done[n] | m_err[n]);
        wr_ok = (m_phase == 0) && csr_wr_i;
        prev = m_phase;
        if (m_phase == 0) begin
            if (csr_rd_i && !csr_wr_i) begin
                m_raddr = csr_addr_i;
                m_phase = 1;
            end
        end else if (m_phase < RD_LAT) m_phase++;
        else m_phase = 0;
        if (m_phase == RD_LAT && prev != RD_LAT) m_rd = m_read(m_raddr);
        wch = int'(csr_addr_i) / 16;
        woff = (int'(csr_addr_i) % 16) / 4;
        d = csr_wr_data_i;
        be = csr_be_i;
        go_n = '0;
        ab_n = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            bit sd, se, cd, ce;
            sd = ch_done_i[n]; se = ch_err_i[n]; cd = 0; ce = 0;
            if (wr_ok && wch == n) begin
                if (woff == 0) begin
                    if (be[0]) begin
                        m_en[n] = d[1];
                        if (d[0]) begin
                            if (ch_busy_i[n]) se = 1; else go_n[n] = 1'b1;
                        end
                        ab_n[n] = d[2];
                    end
                    if (be[2]) m_user[n][7:0] = d[23:16];
                    if (be[3]) m_user[n][15:8] = d[31:24];
                end else if (woff == 1) begin
                    if (be[0]) begin cd = d[1]; ce = d[2]; end
                end else if (woff == 2) begin
                    for (int b = 0; b < 4; b++) if (be[b]) m_desc[n][8*b +: 8] = d[8*b +: 8];
                    m_desc[n][1:0] = 2'b00;
                end
            end
            m_done[n] = sd | (m_done[n] & !cd);
            m_err[n]  = se | (m_err[n] & !ce);
        end
        m_go = go_n;
        m_abort = ab_n;
        m_irq = irq_n;
    endtask

    // One clock: check wait_rq on current inputs, cross the edge, check registered outputs.
    task automatic step();
        logic exp_wait;
        #1;
        if (!reset_n) exp_wait = 1'b1;
        else if (m_phase == 0) exp_wait = csr_rd_i & ~csr_wr_i;
        else exp_wait = (m_phase < RD_LAT);
        chk("wait_rq", 32'(csr_wait_rq_o), 32'(exp_wait));
        last_wait = csr_wait_rq_o;
        last_rd = csr_rd_data_o;
        @(posedge clk);
        @(negedge clk);
        m_step();
        chk("go", 32'(ch_go_o), 32'(m_go));
        chk("abort", 32'(ch_abort_o), 32'(m_abort));
        chk("irq", 32'(irq_o), 32'(m_irq));
        chk("rd_data", csr_rd_data_o, m_rd);
        for (int n = 0; n < NUM_CH; n++) begin
            chk($sformatf("ctrl%0d", n), ch_ctrl_o[32*n +: 32], {m_user[n], 14'b0, m_en[n], 1'b0});
            chk($sformatf("desc%0d", n), ch_desc_ptr_o[32*n +: 32], m_desc[n]);
        end
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
        csr_wr_i = 1'b1; csr_rd_i = 1'b0; csr_addr_i = a; csr_wr_data_i = d; csr_be_i = be;
        step();
        csr_wr_i = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, output logic [31:0] d, output int waits);
        bit got;
        got = 0; waits = 0; d = '0;
        csr_wr_i = 1'b0; csr_rd_i = 1'b1; csr_addr_i = a;
        for (int k = 0; k < 12 && !got; k++) begin
            step();
            if (last_wait) waits++;
            else begin d = last_rd; got = 1; end
        end
        csr_rd_i = 1'b0;
        if (!got) chk("read_timeout", 32'd1, 32'd0);
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return ADDR_W'(16 * $urandom_range(0, NUM_CH-1) + 4 * $urandom_range(0, 3) + $urandom_range(0, 3));
        if (r < 9) return ADDR_W'(16 * NUM_CH + 4 * $urandom_range(0, 3));
        return ADDR_W'($urandom);
    endfunction

    initial begin
        logic [31:0] d;
        int w;
        m_clear();
        reset_n = 1'b0;
        repeat (3) step();
        chk("rst_ctrl0", ch_ctrl_o[31:0], 32'h0);
        chk("rst_irq", 32'(irq_o), 32'h0);
        reset_n = 1'b1;
        step();

        do_write(8'h18, 32'h1234_5677, 4'hF);
        chk("desc1_lit", ch_desc_ptr_o[63:32], 32'h1234_5674);
        chk("desc1_model", m_desc[1], 32'h1234_5674);
        do_read(8'h18, d, w);
        chk("rd_desc1", d, 32'h1234_5674);
        chk("rd_lat", 32'(w), 32'd2);

        do_write(8'h00, 32'hABCD_0003, 4'b1001);
        chk("go0_pulse", 32'(ch_go_o), 32'h1);
        step();
        chk("go0_off", 32'(ch_go_o), 32'h0);
        do_read(8'h00, d, w);
        chk("rd_ctrl0", d, 32'hAB00_0002);

        do_write(8'h20, 32'h2, 4'h1);
        ch_done_i = 4'b0100;
        step();
        ch_done_i = '0;
        chk("irq_not_yet", 32'(irq_o), 32'h0);
        step();
        chk("irq_rise", 32'(irq_o), 32'h1);
        do_read(8'h24, d, w);
        chk("st2_done", d, 32'h2);
        do_read(8'h40, d, w);
        chk("irq_pend", d, 32'h4);
        ch_done_i = 4'b0100;
        do_write(8'h24, 32'h2, 4'h1);
        ch_done_i = '0;
        do_read(8'h24, d, w);
        chk("st2_set_wins", d, 32'h2);
        do_write(8'h24, 32'h2, 4'h1);
        chk("irq_hold", 32'(irq_o), 32'h1);
        step();
        chk("irq_fall", 32'(irq_o), 32'h0);

        ch_busy_i = 4'b1000;
        do_write(8'h30, 32'h1, 4'h1);
        chk("go3_blocked", 32'(ch_go_o), 32'h0);
        do_read(8'h34, d, w);
        chk("st3_busy_err", d, 32'h5);
        ch_busy_i = '0;

        do_read(8'hFC, d, w);
        chk("unmapped", d, 32'h0);
        do_read(8'h44, d, w);
        chk("id", d, ID_VALUE);

        csr_wr_i = 1'b1; csr_rd_i = 1'b1; csr_addr_i = 8'h38;
        csr_wr_data_i = 32'hCAFE_F00D; csr_be_i = 4'hF;
        step();
        chk("simul_wait", 32'(last_wait), 32'h0);
        csr_wr_i = 1'b0; csr_rd_i = 1'b0;
        step();
        chk("simul_desc3", ch_desc_ptr_o[127:96], 32'hCAFE_F00C);
        chk("simul_no_rd", csr_rd_data_o, ID_VALUE);

        csr_rd_i = 1'b1; csr_addr_i = 8'h18;
        step();
        reset_n = 1'b0;
        step();
        chk("rst_wait", 32'(last_wait), 32'h1);
        csr_rd_i = 1'b0;
        step();
        chk("rst_desc1", ch_desc_ptr_o[63:32], 32'h0);
        chk("rst_rd_data", csr_rd_data_o, 32'h0);
        reset_n = 1'b1;
        step();
        chk("idle_after_rst", 32'(last_wait), 32'h0);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 7) == 0) ch_busy_i = NUM_CH'($urandom);
            for (int n = 0; n < NUM_CH; n++) begin
                ch_done_i[n] = ($urandom_range(0, 9) == 0);
                ch_err_i[n]  = ($urandom_range(0, 15) == 0);
            end
            reset_n = ($urandom_range(0, 299) != 0);
            if (m_phase > 0) begin
                csr_rd_i = 1'b1;
                csr_wr_i = ($urandom_range(0, 3) == 0);
                csr_wr_data_i = $urandom;
                csr_be_i = 4'($urandom);
            end else begin
                int r;
                r = $urandom_range(0, 9);
                csr_addr_i = rand_addr();
                csr_wr_data_i = $urandom;
                csr_be_i = 4'($urandom);
                csr_wr_i = (r >= 3 && r <= 6) || r == 9;
                csr_rd_i = (r >= 7);
            end
            step();
        end

        csr_wr_i = 1'b0; csr_rd_i = 1'b0; ch_done_i = '0; ch_err_i = '0; reset_n = 1'b1;
        repeat (4) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
